// File: rtl/aegnn_pkg.sv
// Shared grid geometry for the AEGNN pooling pipeline.
package aegnn;
   localparam int F_WIDTH    = 8;
   localparam int GRID_NUM   = 16;
   localparam int GRID_IDX_W = $clog2(GRID_NUM);
   typedef logic [GRID_IDX_W-1:0] grid_idx_t;
endpackage

// File: rtl/pool_grid_ram.sv
// Simple dual-port storage for pooled grid vectors; read-first when addresses collide.
module pool_grid_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             re,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem_r [DEPTH];

   // Write port; contents are never cleared, the reader masks stale words.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port; the old word wins on a same-cycle write.
   always_ff @(posedge clk) begin
      if (re) begin
         rd_data <= mem_r[rd_addr];
      end
   end
endmodule

// File: rtl/pool_grid_reader.sv
// Stores pooled max vectors per grid entry and streams all entries out on request,
// masking entries not written since the last event-stream clear.
module pool_grid_reader
   import aegnn::*;
#(
   parameter int L4_OUT_C = 32
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         event_stream_clean,
   input  logic                         wr_en,
   input  grid_idx_t                    wr_grid_idx,
   input  logic [L4_OUT_C*F_WIDTH-1:0]  wr_data,
   input  logic                         readout_start,
   output logic                         readout_busy,
   output logic                         readout_done,
   output logic                         out_valid,
   input  logic                         out_ready,
   output grid_idx_t                    out_grid_idx,
   output logic                         out_entry_valid,
   output logic [L4_OUT_C*F_WIDTH-1:0]  out_data
);
   localparam int        D_W      = L4_OUT_C * F_WIDTH;
   localparam grid_idx_t LAST_IDX = grid_idx_t'(GRID_NUM - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   grid_idx_t           idx_r;
   logic [GRID_NUM-1:0] valid_r;
   logic                entry_valid_r;
   logic [D_W-1:0]      ram_q_s;
   logic                rd_en_s;
   logic                accept_s;

   assign accept_s = (state_r == PRESENT) && out_ready;

   pool_grid_ram #(
      .DEPTH (GRID_NUM),
      .WIDTH (D_W),
      .AW    (GRID_IDX_W)
   ) u_ram (
      .clk     (clk),
      .we      (wr_en),
      .wr_addr (wr_grid_idx),
      .wr_data (wr_data),
      .re      (rd_en_s),
      .rd_addr (idx_r),
      .rd_data (ram_q_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; a clear overrides everything, including a start.
   always_comb begin
      state_nxt_s = state_r;
      if (event_stream_clean) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (readout_start) state_nxt_s = FETCH;
               else               state_nxt_s = IDLE;
            end
            FETCH:   state_nxt_s = PRESENT;
            PRESENT: begin
               if (accept_s) begin
                  if (idx_r == LAST_IDX) state_nxt_s = DONE;
                  else                   state_nxt_s = FETCH;
               end else begin
                  state_nxt_s = PRESENT;
               end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State decode for handshake, status and RAM read enable.
   always_comb begin
      out_valid    = 1'b0;
      readout_busy = 1'b0;
      readout_done = 1'b0;
      rd_en_s      = 1'b0;
      case (state_r)
         FETCH: begin
            readout_busy = 1'b1;
            rd_en_s      = 1'b1;
         end
         PRESENT: begin
            out_valid    = 1'b1;
            readout_busy = 1'b1;
         end
         DONE:    readout_done = 1'b1;
         default: out_valid    = 1'b0;
      endcase
   end

   // Scan index: loaded on start, advanced on each non-final accept.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_r <= grid_idx_t'(0);
      end else if (event_stream_clean) begin
         idx_r <= grid_idx_t'(0);
      end else if ((state_r == IDLE) && readout_start) begin
         idx_r <= grid_idx_t'(0);
      end else if (accept_s && (idx_r != LAST_IDX)) begin
         idx_r <= idx_r + grid_idx_t'(1);
      end else begin
         idx_r <= idx_r;
      end
   end

   // Per-entry written flags; the clear beats a coincident write.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_r <= {GRID_NUM{1'b0}};
      end else if (event_stream_clean) begin
         valid_r <= {GRID_NUM{1'b0}};
      end else if (wr_en) begin
         valid_r[wr_grid_idx] <= 1'b1;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Valid bit captured alongside the RAM read so both are read-first.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         entry_valid_r <= 1'b0;
      end else if (event_stream_clean) begin
         entry_valid_r <= 1'b0;
      end else if (state_r == FETCH) begin
         entry_valid_r <= valid_r[idx_r];
      end else begin
         entry_valid_r <= entry_valid_r;
      end
   end

   assign out_grid_idx    = idx_r;
   assign out_entry_valid = entry_valid_r;
   assign out_data        = entry_valid_r ? ram_q_s : {D_W{1'b0}};
endmodule
